// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: edge capture into PEND, MASK gating,
// lowest-index priority, and an IDLE/REQ/SERV handshake with the core.
module intr_ctrl #(
  parameter int              ABITS  = 16,
  parameter int              DBITS  = 16,
  parameter logic [ABITS-1:0] RBASE = 16'hFFD0,
  parameter int              NSRC   = 3,
  parameter int              IDBITS = 2
) (
  input  logic              CLK,
  input  logic              INIT,
  input  logic [ABITS-1:0]  ABUS,
  inout  wire  [DBITS-1:0]  RBUS,
  input  logic              RE,
  input  logic [DBITS-1:0]  WBUS,
  input  logic              WE,
  input  logic [NSRC-1:0]   SRC,
  output logic              IRQ,
  output logic [IDBITS-1:0] IRQID,
  input  logic              ACK,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_SERV = 2'd2} state_t;

  localparam logic [ABITS-1:0] A_PEND = RBASE;
  localparam logic [ABITS-1:0] A_MASK = RBASE + ABITS'(2);
  localparam logic [ABITS-1:0] A_STAT = RBASE + ABITS'(4);
  localparam logic [ABITS-1:0] A_EOI  = RBASE + ABITS'(6);

  state_t             r_state;
  logic [NSRC-1:0]    r_src_d;
  logic [NSRC-1:0]    r_pend;
  logic [NSRC-1:0]    r_mask;
  logic               r_irq;
  logic [IDBITS-1:0]  r_irqid;

  logic               w_hit_pend, w_hit_mask, w_hit_stat, w_hit_eoi, w_hit_any;
  logic [NSRC-1:0]    w_edge, w_w1c, w_active, w_claim_oh, w_ack_clr;
  logic               w_any, w_claim_live, w_eoi, w_wr_mask, w_ack_req;
  logic [IDBITS-1:0]  w_win_id;
  logic [DBITS-1:0]   w_rdata;
  logic               w_unused;

  assign w_hit_pend = (ABUS == A_PEND);
  assign w_hit_mask = (ABUS == A_MASK);
  assign w_hit_stat = (ABUS == A_STAT);
  assign w_hit_eoi  = (ABUS == A_EOI);
  assign w_hit_any  = w_hit_pend | w_hit_mask | w_hit_stat | w_hit_eoi;

  assign w_edge     = SRC & ~r_src_d;
  assign w_w1c      = (WE && w_hit_pend) ? WBUS[NSRC-1:0] : '0;
  assign w_wr_mask  = WE && w_hit_mask;
  assign w_eoi      = WE && w_hit_eoi && (r_state == S_SERV);
  assign w_active   = r_pend & r_mask;
  assign w_any      = |w_active;

  // Claimed source as a one-hot, so ACK clearing and the "still live" test share it.
  assign w_claim_oh   = NSRC'(1) << r_irqid;
  assign w_claim_live = |(w_claim_oh & r_pend & r_mask);
  assign w_ack_req    = ACK && (r_state == S_REQ);
  assign w_ack_clr    = w_ack_req ? w_claim_oh : '0;
  assign w_unused     = ^WBUS[DBITS-1:NSRC];

  always_comb begin
    w_win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_win_id = IDBITS'(i);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit_pend) begin
      w_rdata[NSRC-1:0] = r_pend;
    end else if (w_hit_mask) begin
      w_rdata[NSRC-1:0] = r_mask;
    end else if (w_hit_stat) begin
      w_rdata[0]           = r_irq;
      w_rdata[1]           = (r_state == S_SERV);
      w_rdata[4 +: IDBITS] = r_irqid;
    end
  end

  assign RBUS = (RE && w_hit_any) ? w_rdata : {DBITS{1'bz}};

  // Edge set is OR-ed in last, so a same-cycle edge beats W1C and ACK clear.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_src_d <= SRC;
      r_pend  <= '0;
      r_mask  <= '0;
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
      r_irqid <= '0;
    end else begin
      r_src_d <= SRC;
      r_pend  <= (r_pend & ~w_w1c & ~w_ack_clr) | w_edge;
      if (w_wr_mask) r_mask <= WBUS[NSRC-1:0];
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_irqid <= w_win_id;
            r_irq   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (ACK) begin
            r_irq   <= 1'b0;
            r_state <= S_SERV;
          end else if (!w_claim_live) begin
            r_irq   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SERV: begin
          if (w_eoi) r_state <= S_IDLE;
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign IRQ         = r_irq;
  assign IRQID       = r_irqid;
  assign o_dbg_state = r_state;

endmodule
